// File: rtl/lifo_reader_if.sv
// Stack read port, start/length control and valid/ready output stream of lifo_reader.
interface lifo_reader_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 4
) ();
  logic              start;
  logic [CNT_W-1:0]  len;
  logic              lifo_empty;
  logic              lifo_re;
  logic [DATA_W-1:0] lifo_dout;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  word_cnt;

  // Reader side
  modport master (
    input  start, len, lifo_empty, lifo_dout, m_ready,
    output lifo_re, m_data, m_valid, busy, done, word_cnt
  );

  // Environment side (stack, controller and output sink)
  modport slave (
    output start, len, lifo_empty, lifo_dout, m_ready,
    input  lifo_re, m_data, m_valid, busy, done, word_cnt
  );
endinterface

// File: rtl/lifo_reader.sv
// Drains a stack in pop order onto a valid/ready stream through a 2-entry skid buffer.
module lifo_reader #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 4
) (
  input  logic          clk,
  input  logic          rst,
  lifo_reader_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  target_q, target_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              inflight_q;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [1:0]        buf_cnt_q, buf_cnt_d;

  logic              xfer_c;
  logic [2:0]        occ_c;
  logic              pop_c;
  logic              busy_c;
  logic              done_c;
  logic              below_target_c;
  logic              last_pop_c;

  // Head leaves the buffer on this edge
  assign xfer_c = (buf_cnt_q != 2'd0) && bus.m_ready;

  // Buffer occupancy after this edge; a pop issued now lands one edge later,
  // so it is allowed only while that occupancy leaves room for it. Crediting
  // the departing head keeps one word per cycle under full throughput.
  assign occ_c = 3'(buf_cnt_q) - 3'(xfer_c) + 3'(inflight_q);

  assign below_target_c = (target_q == '0) || (cnt_q < target_q);
  assign last_pop_c     = (target_q != '0) && (CNT_W'(cnt_q + CNT_W'(1)) == target_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN: begin
        if ((pop_c && last_pop_c) || (bus.lifo_empty && !pop_c)) state_d = S_FLUSH;
      end
      S_FLUSH: if (!inflight_q && (buf_cnt_q == 2'd0)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs and pop issue
  always_comb begin
    pop_c  = 1'b0;
    busy_c = 1'b0;
    done_c = 1'b0;
    unique case (state_q)
      S_RUN: begin
        busy_c = 1'b1;
        pop_c  = !bus.lifo_empty && (occ_c < 3'd2) && below_target_c;
      end
      S_FLUSH: busy_c = 1'b1;
      S_DONE:  done_c = 1'b1;
      default: ;
    endcase
  end

  // Target/counter and output buffer next state
  always_comb begin
    target_d  = target_q;
    cnt_d     = cnt_q;
    head_d    = head_q;
    tail_d    = tail_q;
    buf_cnt_d = buf_cnt_q;

    if ((state_q == S_IDLE) && bus.start) begin
      target_d = bus.len;
      cnt_d    = '0;
    end else if (pop_c && (cnt_q != '1)) begin
      cnt_d = CNT_W'(cnt_q + CNT_W'(1));
    end

    unique case ({xfer_c, inflight_q})
      2'b11: begin
        if (buf_cnt_q == 2'd1) begin
          head_d = bus.lifo_dout;
        end else begin
          head_d = tail_q;
          tail_d = bus.lifo_dout;
        end
      end
      2'b10: begin
        head_d    = tail_q;
        buf_cnt_d = buf_cnt_q - 2'd1;
      end
      2'b01: begin
        if (buf_cnt_q == 2'd0) head_d = bus.lifo_dout;
        else                   tail_d = bus.lifo_dout;
        buf_cnt_d = buf_cnt_q + 2'd1;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q   <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      buf_cnt_q  <= 2'd0;
    end else begin
      target_q   <= target_d;
      cnt_q      <= cnt_d;
      inflight_q <= pop_c;
      head_q     <= head_d;
      tail_q     <= tail_d;
      buf_cnt_q  <= buf_cnt_d;
    end
  end

  assign bus.lifo_re  = pop_c;
  assign bus.busy     = busy_c;
  assign bus.done     = done_c;
  assign bus.m_data   = head_q;
  assign bus.m_valid  = (buf_cnt_q != 2'd0);
  assign bus.word_cnt = cnt_q;

endmodule

// File: tb/tb_lifo_reader.sv
// Directed scoreboard bench for lifo_reader driving a behavioural stack model.
module tb_lifo_reader;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lifo_reader_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  lifo_reader #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Behavioural stack: empty flag from pointer, data one cycle after a pop
  logic [DATA_W-1:0] stk [0:15];
  int                sp = 0;
  logic              push_v = 1'b0;
  logic              clr_v  = 1'b0;
  logic [DATA_W-1:0] push_d = '0;

  assign bus.lifo_empty = (sp == 0);

  always @(posedge clk) begin
    if (clr_v) begin
      sp <= 0;
    end else if (push_v) begin
      stk[4'(sp)] <= push_d;
      sp <= sp + 1;
    end else if (bus.lifo_re && (sp != 0)) begin
      bus.lifo_dout <= stk[4'(sp - 1)];
      sp <= sp - 1;
    end
  end

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mdl[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_w;

  int   cyc = 0;
  int   re_cnt = 0, done_cnt = 0, out_cnt = 0, val_cnt = 0;
  int   first_x = 0, last_x = 0;
  logic prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;

  // Output monitor: scoreboard compare on transfers, hold check on stalls
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.lifo_re) re_cnt++;
      if (bus.done)    done_cnt++;
      if (bus.m_valid) val_cnt++;
      if (prev_stall) begin
        checks++;
        assert (bus.m_valid === 1'b1 && bus.m_data === prev_data) else begin
          errors++;
          $error("FAIL stall_hold: observed valid=%b data=%0d, expected valid=1 data=%0d",
                 bus.m_valid, bus.m_data, prev_data);
        end
      end
      if (bus.m_valid && bus.m_ready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_out: observed data=%0d, expected no output", bus.m_data);
        end
        if (exp_q.size() != 0) begin
          exp_w = exp_q.pop_front();
          checks++;
          assert (bus.m_data === exp_w) else begin
            errors++;
            $error("FAIL out_data: observed %0d, expected %0d", bus.m_data, exp_w);
          end
        end
        if (out_cnt == 0) first_x = cyc;
        last_x = cyc;
        out_cnt++;
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // All stimulus tasks start and end at posedge+1
  task automatic push_word(input logic [DATA_W-1:0] d);
    push_v = 1'b1;
    push_d = d;
    @(posedge clk); #1;
    push_v = 1'b0;
    mdl.push_back(d);
  endtask

  task automatic clear_stack();
    clr_v = 1'b1;
    @(posedge clk); #1;
    clr_v = 1'b0;
    mdl.delete();
  endtask

  task automatic clr_counters();
    re_cnt = 0; done_cnt = 0; out_cnt = 0; val_cnt = 0;
  endtask

  task automatic start_drain(input logic [CNT_W-1:0] l);
    int n;
    n = (l == 0) ? mdl.size() : ((int'(l) < mdl.size()) ? int'(l) : mdl.size());
    for (int i = 0; i < n; i++) exp_q.push_back(mdl.pop_back());
    bus.start = 1'b1;
    bus.len   = l;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int c);
    c = 0;
    while (c < 200) begin
      @(negedge clk);
      c++;
      if (bus.done) break;
    end
    chk(tag, 32'(bus.done), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  int c;

  initial begin
    rst = 1'b1;
    bus.start   = 1'b0;
    bus.len     = '0;
    bus.m_ready = 1'b1;
    clr_v = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_lifo_re",  32'(bus.lifo_re),  32'd0);
    chk("rst_m_valid",  32'(bus.m_valid),  32'd0);
    chk("rst_m_data",   32'(bus.m_data),   32'd0);
    chk("rst_busy",     32'(bus.busy),     32'd0);
    chk("rst_done",     32'(bus.done),     32'd0);
    chk("rst_word_cnt", 32'(bus.word_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    clr_v = 1'b0;

    // Full drain, len=0, full throughput
    push_word(8'd10); push_word(8'd20); push_word(8'd30); push_word(8'd40);
    clr_counters();
    start_drain(4'd0);
    wait_done("t1_done_seen", c);
    settle();
    chk("t1_outputs",  32'(out_cnt), 32'd4);
    chk("t1_re_cycles", 32'(re_cnt), 32'd4);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_word_cnt", 32'(bus.word_cnt), 32'd4);
    chk("t1_consec",   32'(last_x - first_x), 32'd3);
    chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("t1_busy",     32'(bus.busy), 32'd0);

    // Length-limited drain leaves the rest on the stack
    push_word(8'd10); push_word(8'd20); push_word(8'd30); push_word(8'd40);
    clr_counters();
    start_drain(4'd2);
    wait_done("t2_done_seen", c);
    settle();
    chk("t2_outputs",  32'(out_cnt), 32'd2);
    chk("t2_word_cnt", 32'(bus.word_cnt), 32'd2);
    chk("t2_done_cnt", 32'(done_cnt), 32'd1);
    chk("t2_empty",    32'(bus.lifo_empty), 32'd0);
    chk("t2_left",     32'(sp), 32'd2);
    chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure: only two pops outstanding, head held
    clear_stack();
    push_word(8'd5); push_word(8'd6); push_word(8'd7);
    bus.m_ready = 1'b0;
    clr_counters();
    start_drain(4'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("t3_re_stalled", 32'(re_cnt), 32'd2);
    chk("t3_head",       32'(bus.m_data), 32'd7);
    chk("t3_valid",      32'(bus.m_valid), 32'd1);
    bus.m_ready = 1'b1;
    wait_done("t3_done_seen", c);
    settle();
    chk("t3_outputs",  32'(out_cnt), 32'd3);
    chk("t3_word_cnt", 32'(bus.word_cnt), 32'd3);
    chk("t3_done_cnt", 32'(done_cnt), 32'd1);
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // Empty stack with nonzero length
    clr_counters();
    start_drain(4'd3);
    wait_done("t4_done_seen", c);
    chk("t4_done_lat", 32'(c), 32'd3);
    settle();
    chk("t4_re",       32'(re_cnt), 32'd0);
    chk("t4_valid",    32'(val_cnt), 32'd0);
    chk("t4_word_cnt", 32'(bus.word_cnt), 32'd0);
    chk("t4_done_cnt", 32'(done_cnt), 32'd1);

    // Second start while busy is ignored
    for (int i = 1; i <= 8; i++) push_word(8'(100 + i));
    clr_counters();
    start_drain(4'd0);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.len   = 4'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done("t5_done_seen", c);
    settle();
    chk("t5_outputs",  32'(out_cnt), 32'd8);
    chk("t5_word_cnt", 32'(bus.word_cnt), 32'd8);
    chk("t5_done_cnt", 32'(done_cnt), 32'd1);
    chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset one cycle after the first pop
    clear_stack();
    push_word(8'd1); push_word(8'd2); push_word(8'd3); push_word(8'd4);
    clr_counters();
    bus.start = 1'b1;
    bus.len   = 4'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    void'(mdl.pop_back());
    #1;
    chk("t6_rst_lifo_re",  32'(bus.lifo_re),  32'd0);
    chk("t6_rst_m_valid",  32'(bus.m_valid),  32'd0);
    chk("t6_rst_m_data",   32'(bus.m_data),   32'd0);
    chk("t6_rst_busy",     32'(bus.busy),     32'd0);
    chk("t6_rst_done",     32'(bus.done),     32'd0);
    chk("t6_rst_word_cnt", 32'(bus.word_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t6_left",      32'(sp), 32'd3);
    chk("t6_idle_busy", 32'(bus.busy), 32'd0);
    clr_counters();
    start_drain(4'd0);
    wait_done("t6_done_seen", c);
    settle();
    chk("t6_outputs",  32'(out_cnt), 32'd3);
    chk("t6_word_cnt", 32'(bus.word_cnt), 32'd3);
    chk("t6_done_cnt", 32'(done_cnt), 32'd1);
    chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
